// File: rtl/ycc_rgb_row_converter.sv
// Converts one upsampled 8x8 Y/Cb/Cr block triple to 8-bit BT.601 full-range RGB,
// streaming one 8-pixel row per valid/ready beat; next triple accepted as row 7 is presented.
`ifndef Q
`define Q 8
`endif

module ycc_rgb_row_converter #(
  parameter int Q_W    = `Q,
  parameter int FRAC_W = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [7:0][7:0][Q_W-1:0]     y_in,
  input  logic [7:0][7:0][Q_W-1:0]     cb_in,
  input  logic [7:0][7:0][Q_W-1:0]     cr_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [2:0]                   row_out,
  output logic                         last_out,
  output logic [7:0][7:0]              r_out,
  output logic [7:0][7:0]              g_out,
  output logic [7:0][7:0]              b_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Half-LSB rounding constant; collapses to zero when there are no fractional bits.
  localparam logic [Q_W:0] RND = ((Q_W+1)'(1) << FRAC_W) >> 1;

  function automatic logic [7:0] extract(input logic [Q_W-1:0] v);
    logic [Q_W:0] sum;
    logic [Q_W:0] sh;
    sum = {1'b0, v} + RND;
    sh  = sum >> FRAC_W;
    if (|(sh >> 8)) return 8'hff;
    return sh[7:0];
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    if (v < 20'sd0) return 8'd0;
    if (v > 20'sd255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic signed [19:0] widen(input logic [7:0] v);
    return $signed({12'd0, v});
  endfunction

  function automatic logic [7:0] pix_r(input logic [7:0] y, input logic [7:0] cr);
    logic signed [19:0] dcr;
    dcr = widen(cr) - 20'sd128;
    return clamp8(widen(y) + ((20'sd359 * dcr + 20'sd128) >>> 8));
  endfunction

  function automatic logic [7:0] pix_g(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    logic signed [19:0] dcb;
    logic signed [19:0] dcr;
    dcb = widen(cb) - 20'sd128;
    dcr = widen(cr) - 20'sd128;
    return clamp8(widen(y) + ((-20'sd88 * dcb - 20'sd183 * dcr + 20'sd128) >>> 8));
  endfunction

  function automatic logic [7:0] pix_b(input logic [7:0] y, input logic [7:0] cb);
    logic signed [19:0] dcb;
    dcb = widen(cb) - 20'sd128;
    return clamp8(widen(y) + ((20'sd454 * dcb + 20'sd128) >>> 8));
  endfunction

  state_t                 state_q;
  logic [2:0]             row_ptr_q;
  logic [2:0]             row_ptr_d;
  logic [7:0][7:0][7:0]   y_q, cb_q, cr_q;
  logic [7:0][7:0][7:0]   y_d, cb_d, cr_d;
  logic [7:0][7:0]        conv_r, conv_g, conv_b;
  logic                   valid_q, last_q;
  logic [2:0]             row_q;
  logic [7:0][7:0]        r_q, g_q, b_q;
  logic                   load;

  assign ready_out = (state_q == IDLE) && !rst;
  assign load      = (state_q == BUSY) && (!valid_q || ready_in);
  assign row_ptr_d = row_ptr_q + 3'd1;

  // Samples are reduced to 8 bits at capture so the buffer only holds integer values.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        y_d[r][c]  = extract(y_in[r][c]);
        cb_d[r][c] = extract(cb_in[r][c]);
        cr_d[r][c] = extract(cr_in[r][c]);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      conv_r[c] = pix_r(y_q[row_ptr_q][c], cr_q[row_ptr_q][c]);
      conv_g[c] = pix_g(y_q[row_ptr_q][c], cb_q[row_ptr_q][c], cr_q[row_ptr_q][c]);
      conv_b[c] = pix_b(y_q[row_ptr_q][c], cb_q[row_ptr_q][c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_ptr_q <= 3'd0;
      valid_q   <= 1'b0;
      row_q     <= 3'd0;
      last_q    <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      if (valid_q && ready_in) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            y_q       <= y_d;
            cb_q      <= cb_d;
            cr_q      <= cr_d;
            row_ptr_q <= 3'd0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (load) begin
            r_q       <= conv_r;
            g_q       <= conv_g;
            b_q       <= conv_b;
            row_q     <= row_ptr_q;
            last_q    <= (row_ptr_q == 3'd7);
            valid_q   <= 1'b1;
            row_ptr_q <= row_ptr_d;
            if (row_ptr_q == 3'd7) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_out = valid_q;
  assign row_out   = row_q;
  assign last_out  = last_q;
  assign r_out     = r_q;
  assign g_out     = g_q;
  assign b_out     = b_q;

endmodule

// File: tb/tb_ycc_rgb_row_converter.sv
// Bench for ycc_rgb_row_converter: directed and random blocks checked against an integer colour model.
module tb_ycc_rgb_row_converter;
  localparam int QW = 10;
  localparam int FW = 2;

  typedef logic [7:0][7:0][QW-1:0] blk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid_in, ready_out, valid_out, ready_in, last_out;
  blk_t y_in, cb_in, cr_in;
  logic [2:0] row_out;
  logic [7:0][7:0] r_out, g_out, b_out;

  ycc_rgb_row_converter #(.Q_W(QW), .FRAC_W(FW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .valid_out(valid_out), .ready_in(ready_in), .row_out(row_out),
    .last_out(last_out), .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  int vectors = 0;
  int miscompares = 0;
  blk_t raw_y[2], raw_cb[2], raw_cr[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: rounded sample extraction, floor division by 256, clamp.
  function automatic int ext(input int raw);
    int v;
    v = (raw + ((1 << FW) / 2)) / (1 << FW);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int fdiv256(input int a);
    return (a >= 0) ? a / 256 : -((-a + 255) / 256);
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  task automatic exp_row(input int blk, input int row,
                         output logic [7:0][7:0] er, output logic [7:0][7:0] eg,
                         output logic [7:0][7:0] eb);
    int yv, cb, cr;
    for (int c = 0; c < 8; c++) begin
      yv = ext(int'(raw_y[blk][row][c]));
      cb = ext(int'(raw_cb[blk][row][c])) - 128;
      cr = ext(int'(raw_cr[blk][row][c])) - 128;
      er[c] = 8'(clamp(yv + fdiv256(359 * cr + 128)));
      eg[c] = 8'(clamp(yv + fdiv256(-88 * cb - 183 * cr + 128)));
      eb[c] = 8'(clamp(yv + fdiv256(454 * cb + 128)));
    end
  endtask

  task automatic set_const(input int blk, input int yv, input int cb, input int cr);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        raw_y[blk][r][c]  = QW'(yv << FW);
        raw_cb[blk][r][c] = QW'(cb << FW);
        raw_cr[blk][r][c] = QW'(cr << FW);
      end
  endtask

  task automatic set_rand(input int blk);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        raw_y[blk][r][c]  = QW'($urandom_range(0, 1023));
        raw_cb[blk][r][c] = QW'($urandom_range(0, 1023));
        raw_cr[blk][r][c] = QW'($urandom_range(0, 1023));
      end
  endtask

  // Sends nblk triples (valid_in held between them) and checks every presented row.
  // Called and returns at a negedge.
  task automatic run(input int nblk, input int stall_row, input int stall_n,
                     output int cycles, output int gaps);
    int exp_idx, sent, guard, stall_left;
    bit cap, started, stalled;
    logic [7:0][7:0] er, eg, eb;
    exp_idx = 0; sent = 0; guard = 0; cycles = 0; gaps = 0; stall_left = stall_n;
    cap = 0; started = 0; stalled = 0;
    y_in = raw_y[0]; cb_in = raw_cb[0]; cr_in = raw_cr[0];
    valid_in = 1'b1; ready_in = 1'b1;
    while (exp_idx < nblk * 8 && guard < 400) begin
      if (started) cycles++;
      if (valid_in && ready_out) begin
        cap = 1;
        if (sent > 0) begin
          chk("cap_on_row7_vld", 64'(valid_out), 64'd1);
          chk("cap_on_row7_row", 64'(row_out), 64'd7);
        end
      end
      if (stalled) chk("hold_vld", 64'(valid_out), 64'd1);
      if (valid_out) begin
        if (int'(row_out) == stall_row && stall_left > 0) begin
          ready_in = 1'b0; stall_left--; stalled = 1;
        end else begin
          ready_in = 1'b1; stalled = 0;
        end
        exp_row(exp_idx / 8, exp_idx % 8, er, eg, eb);
        chk("row_out", 64'(row_out), 64'(exp_idx % 8));
        chk("last_out", 64'(last_out), 64'(exp_idx % 8 == 7));
        chk("r_out", 64'(r_out), 64'(er));
        chk("g_out", 64'(g_out), 64'(eg));
        chk("b_out", 64'(b_out), 64'(eb));
        if (ready_in) exp_idx++;
      end else begin
        ready_in = 1'b1; stalled = 0;
        if (started && exp_idx > 0 && exp_idx < nblk * 8) gaps++;
      end
      @(negedge clk);
      guard++;
      if (cap) begin
        cap = 0; started = 1; sent++;
        chk("rdy_drop", 64'(ready_out), 64'd0);
        if (sent < nblk) begin
          y_in = raw_y[sent]; cb_in = raw_cb[sent]; cr_in = raw_cr[sent];
        end else valid_in = 1'b0;
      end
    end
    chk("rows_delivered", 64'(exp_idx), 64'(nblk * 8));
    valid_in = 1'b0; ready_in = 1'b1;
  endtask

  initial begin
    int cyc, gp, n;
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    y_in = '0; cb_in = '0; cr_in = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd0);
    chk("rst_row", 64'(row_out), 64'd0);
    chk("rst_last", 64'(last_out), 64'd0);
    chk("rst_rgb", 64'(r_out) | 64'(g_out) | 64'(b_out), 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", 64'(ready_out), 64'd1);
    @(negedge clk);

    set_const(0, 128, 128, 128);
    run(1, -1, 0, cyc, gp);
    chk("blk_cycles", 64'(cyc), 64'd9);
    chk("blk_gaps", 64'(gp), 64'd0);

    set_const(0, 0, 128, 255);   run(1, -1, 0, cyc, gp);
    set_const(0, 255, 255, 128); run(1, -1, 0, cyc, gp);
    set_const(0, 100, 0, 0);     run(1, -1, 0, cyc, gp);

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        raw_y[0][r][c]  = QW'((r * 8 + c) << FW);
        raw_cb[0][r][c] = QW'(128 << FW);
        raw_cr[0][r][c] = QW'(128 << FW);
      end
    run(1, -1, 0, cyc, gp);

    set_rand(0);
    run(1, 2, 3, cyc, gp);
    chk("stall_cycles", 64'(cyc), 64'd12);

    set_rand(0); set_rand(1);
    run(2, -1, 0, cyc, gp);
    chk("b2b_cycles", 64'(cyc), 64'd18);
    chk("b2b_gaps", 64'(gp), 64'd1);

    // Reset while row 4 is held by downstream backpressure.
    set_rand(0);
    y_in = raw_y[0]; cb_in = raw_cb[0]; cr_in = raw_cr[0];
    valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    n = 0;
    while (!(valid_out && row_out == 3'd4) && n < 20) begin
      @(negedge clk); n++;
    end
    chk("reach_row4", 64'(row_out), 64'd4);
    ready_in = 1'b0;
    @(negedge clk);
    chk("row4_held", 64'(row_out), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_ready", 64'(ready_out), 64'd0);
    chk("midrst_row", 64'(row_out), 64'd0);
    chk("midrst_rgb", 64'(r_out) | 64'(g_out) | 64'(b_out), 64'd0);
    rst = 1'b0;
    #1 chk("midrst_ready_up", 64'(ready_out), 64'd1);
    @(negedge clk);
    ready_in = 1'b1;
    set_rand(0);
    run(1, -1, 0, cyc, gp);

    for (int i = 0; i < 6; i++) begin
      set_rand(0); set_rand(1);
      run((i % 2) + 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), cyc, gp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ycc_rgb_row_converter.md
Name: ycc_rgb_row_converter

Overview:
- Stage directly downstream of the supersample buffer.
- Accepts one fully upsampled 8x8 Y/Cb/Cr block triple per transfer, with all three channels presented in parallel.
- Converts the triple to 8-bit RGB using fixed-point BT.601 full-range coefficients.
- Streams the result out one 8-pixel row per beat under a valid/ready handshake, feeding the pixel writer.

Parameters:
Q_W, `Q, bit width of each incoming sample.
FRAC_W, 0, number of fractional bits in each incoming sample. The integer part is the 8 MSBs above FRAC_W.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
valid_in  input  1  upstream block triple valid
ready_out  output  1  block can accept a triple this cycle
y_in  input  [7:0][7:0] x Q_W  luma block; y_in[r][c] is row r, column c
cb_in  input  [7:0][7:0] x Q_W  upsampled Cb block
cr_in  input  [7:0][7:0] x Q_W  upsampled Cr block
valid_out  output  1  output row valid
ready_in  input  1  downstream accepts row
row_out  output  3  index of the row being presented (0..7)
last_out  output  1  high with row 7
r_out  output  [7:0] x 8  red, pixel c of row
g_out  output  [7:0] x 8  green
b_out  output  [7:0] x 8  blue

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, row_ptr=0, valid_out=0, row_out=0, last_out=0, r/g/b_out=0.
  - ready_out is forced to 0 while rst is high.
  - Reset mid-block discards the block and any held output row.
- FSM:
  - IDLE: ready_out=1. On valid_in&ready_out, register y/cb/cr into the internal buffer, row_ptr<=0, go to BUSY.
  - BUSY: ready_out=0. valid_in is ignored; upstream must hold its data.
- Output register load condition: state==BUSY and (valid_out==0 or ready_in==1). On a load:
  - The register takes the converted row row_ptr, row_out<=row_ptr, last_out<=(row_ptr==7), valid_out<=1.
  - row_ptr increments. When the loaded row is 7, row_ptr wraps to 0 and the state goes to IDLE.
- When valid_out&ready_in and no load occurs, valid_out<=0.
- When valid_out&!ready_in, all outputs hold stable.
- Latency and throughput:
  - Capture at edge k gives row 0 valid after edge k+1.
  - With ready_in held at 1: rows on 8 consecutive cycles, one bubble cycle, then the next block. Throughput is 9 cycles per block.
  - A new triple can be captured on the cycle row 7 is presented.
- Sample extraction:
  - s = (in + (FRAC_W>0 ? 2^(FRAC_W-1) : 0)) >> FRAC_W, saturated to 255.
  - Y, Cb, Cr are unsigned 8-bit values.
- Arithmetic, signed, at least 18 bits, with >>> as arithmetic shift (floor):
  - dcb = Cb-128, dcr = Cr-128 (9-bit signed).
  - R = Y + ((359*dcr + 128) >>> 8)
  - G = Y + ((-88*dcb - 183*dcr + 128) >>> 8)
  - B = Y + ((454*dcb + 128) >>> 8)
  - Each result is clamped to [0,255].
- Conversion happens combinationally from the buffered row into the output register. There is no extra pipeline stage.

Test Plan:
- Reset, then an all-128 triple with ready_in=1 -> ready_out drops after capture; 8 rows, row_out 0..7, last_out only on row 7; every pixel R=G=B=128.
- Y=0, Cb=128, Cr=255 -> R=178, G=0, B=0. Y=255, Cb=255, Cr=128 -> R=255, G=211, B=255. Y=100, Cb=0, Cr=0 -> R=0, G=236, B=0.
- Ramp Y=r*8+c, Cb=Cr=128 -> r_out[c] of row r equals r*8+c, confirming row/column ordering.
- ready_in low for 3 cycles during row 2 -> row 2 held stable, no row skipped or duplicated, row 3 follows after ready_in returns.
- Back-to-back triples with valid_in held 1 and ready_in=1 -> second capture on the cycle row 7 is presented; exactly one valid_out=0 gap; 16 rows total in 18 cycles after the first capture.
- rst asserted while row 4 is pending with ready_in=0 -> next cycle valid_out=0, then ready_out=1; a new triple restarts from row 0.
